// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave from the board MCU, fanned out as a one-hot byte-strobe bus to TARGETS blocks.
// Latency: 3 clk from the 8th spi_clk pin rise to the mcu_strobe pulse; reply loaded into TX one cycle after the strobe.
// Backpressure: none; targets must accept one byte per strobe, and clk must be at least 8x spi_clk.
module mcu_spi_slave #(
  parameter int TARGETS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   spi_clk,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic [TARGETS-1:0]     mcu_strobe,
  output logic                   mcu_start,
  output logic [7:0]             mcu_dout,
  input  logic [8*TARGETS-1:0]   mcu_din
);

  typedef enum logic [1:0] {IDLE, TARGET, CMD, DATA} state_t;

  logic [2:0]         sclk_sync;
  logic [1:0]         cs_sync;
  logic [1:0]         mosi_sync;
  logic               rise;
  logic               fall;
  logic               cs_n_s;
  logic               mosi_s;

  state_t             state;
  logic [2:0]         bit_cnt;
  logic [6:0]         rx_shift;
  logic [7:0]         rx_byte;
  logic [7:0]         tx_shift;
  logic [7:0]         tgt_id;
  logic               load_d1;
  logic               load_d2;

  logic [TARGETS-1:0] sel_hot;
  logic [7:0]         reply;

  // Bring the asynchronous SPI pins into the clk domain; spi_clk gets a third stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  assign rise    = sclk_sync[1] & ~sclk_sync[2];
  assign fall    = ~sclk_sync[1] & sclk_sync[2];
  assign cs_n_s  = cs_sync[1];
  assign mosi_s  = mosi_sync[1];
  assign rx_byte = {rx_shift, mosi_s};

  // Decode the latched target id into a one-hot strobe and its reply byte; an out-of-range id selects nothing and replies 0x00.
  always_comb begin
    sel_hot = '0;
    reply   = '0;
    for (int i = 0; i < TARGETS; i++) begin
      if (tgt_id == 8'(i)) begin
        sel_hot[i] = 1'b1;
        reply      = mcu_din[8*i +: 8];
      end
    end
  end

  // Frame FSM: byte assembly, strobe generation and the MISO transmit shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      tgt_id     <= '0;
      load_d1    <= 1'b0;
      load_d2    <= 1'b0;
      mcu_strobe <= '0;
      mcu_start  <= 1'b0;
      mcu_dout   <= '0;
    end else begin
      mcu_strobe <= '0;
      mcu_start  <= 1'b0;
      load_d1    <= 1'b0;
      load_d2    <= load_d1;
      if (cs_n_s) begin
        // Deselected: drop any partial byte and pending reply load; issued strobes stand.
        state    <= IDLE;
        bit_cnt  <= '0;
        tx_shift <= '0;
        load_d1  <= 1'b0;
        load_d2  <= 1'b0;
      end else begin
        if (state == IDLE) begin
          state <= TARGET;
        end
        // The reply is taken one cycle after the strobe so the target has had a cycle to update it.
        // The fall that closes a byte (bit_cnt back at 0) is not a shift: the freshly loaded MSB must
        // stay on MISO until the MCU samples it on the next rise.
        if (load_d2) begin
          tx_shift <= reply;
        end else if (fall && bit_cnt != 3'd0) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
        if (rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            load_d1 <= 1'b1;
            case (state)
              TARGET: begin
                tgt_id <= rx_byte;
                state  <= CMD;
              end
              CMD: begin
                if (|sel_hot) begin
                  mcu_dout <= rx_byte;
                end
                mcu_strobe <= sel_hot;
                mcu_start  <= |sel_hot;
                state      <= DATA;
              end
              DATA: begin
                if (|sel_hot) begin
                  mcu_dout <= rx_byte;
                end
                mcu_strobe <= sel_hot;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign spi_miso = tx_shift[7];

endmodule

// File: tb/tb_mcu_spi_slave.sv
`timescale 1ns/1ps
// Bench for mcu_spi_slave: drives SPI frames as the MCU and emulates the four targets.
// Expectations come from a frame-level model: strobe list per frame and the reply byte the MCU should see.
// The targets answer each strobe with the next queued reply byte.
module tb_mcu_spi_slave;

  localparam int TARGETS = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] tid;
    logic [7:0] dat;
    logic       start;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 spi_clk = 1'b0;
  logic                 spi_cs_n = 1'b1;
  logic                 spi_mosi = 1'b0;
  logic                 spi_miso;
  logic [TARGETS-1:0]   mcu_strobe;
  logic                 mcu_start;
  logic [7:0]           mcu_dout;
  logic [8*TARGETS-1:0] mcu_din;

  logic [7:0] cur_din [TARGETS] = '{default: 8'h00};
  exp_t       exp_q[$];
  logic [7:0] reply_q[$];

  int tests = 0;
  int fails = 0;
  int strobe_seen = 0;
  logic [TARGETS-1:0] last_strobe = '0;
  logic [7:0]         last_dout = '0;
  logic               last_start = 1'b0;
  logic               zero_watch = 1'b0;

  assign mcu_din = {cur_din[3], cur_din[2], cur_din[1], cur_din[0]};

  mcu_spi_slave #(.TARGETS(TARGETS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .mcu_strobe (mcu_strobe),
    .mcu_start  (mcu_start),
    .mcu_dout   (mcu_dout),
    .mcu_din    (mcu_din)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process and target emulation: every strobe must match the head of the model's list.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (zero_watch) check("miso_zero", {31'd0, spi_miso}, 32'd0);
      if (mcu_strobe !== '0) begin
        strobe_seen++;
        last_strobe = mcu_strobe;
        last_dout   = mcu_dout;
        last_start  = mcu_start;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {28'd0, mcu_strobe}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_onehot", {28'd0, mcu_strobe}, {28'd0, 4'b0001 << e.tid});
          check("strobe_dout", {24'd0, mcu_dout}, {24'd0, e.dat});
          check("strobe_start", {31'd0, mcu_start}, {31'd0, e.start});
          if (reply_q.size() > 0) cur_din[e.tid[1:0]] = reply_q.pop_front();
        end
      end
    end
  end

  task automatic xfer(input logic [7:0] b, input int nbits, input int half, output logic [7:0] mb);
    mb = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (half) @(negedge clk);
      spi_clk = 1'b1;
      mb[i] = spi_miso;
      repeat (half) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  // Record what a frame must produce: strobes for bytes 1.. of a valid target, replies the target will give.
  task automatic frame_setup(input bq_t bytes, input bq_t replies, output bq_t expm);
    logic [7:0] tid;
    logic       valid;
    tid   = bytes[0];
    valid = (tid < TARGETS);
    expm  = {};
    expm.push_back(8'h00);
    for (int k = 1; k < bytes.size(); k++) begin
      if (!valid)      expm.push_back(8'h00);
      else if (k == 1) expm.push_back(cur_din[tid[1:0]]);
      else             expm.push_back(replies[k-2]);
    end
    if (valid) begin
      for (int k = 1; k < bytes.size(); k++) exp_q.push_back('{tid, bytes[k], (k == 1)});
      foreach (replies[j]) reply_q.push_back(replies[j]);
    end
  endtask

  task automatic run_frame(input bq_t bytes, input bq_t replies, input int half, output bq_t got);
    bq_t        expm;
    logic [7:0] mb;
    frame_setup(bytes, replies, expm);
    got = {};
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < bytes.size(); k++) begin
      xfer(bytes[k], 8, half, mb);
      got.push_back(mb);
      check($sformatf("miso_byte%0d", k), {24'd0, mb}, {24'd0, expm[k]});
    end
    repeat (6) @(negedge clk);
    check("frame_drain", exp_q.size(), 0);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    bq_t        b;
    bq_t        r;
    bq_t        got;
    bq_t        expm;
    logic [7:0] mb;
    int         s0;
    int         len;

    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_strobe", {28'd0, mcu_strobe}, 32'd0);
    check("rst_start", {31'd0, mcu_start}, 32'd0);
    check("rst_dout", {24'd0, mcu_dout}, 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // sys frame: replies arrive one byte late
    s0 = strobe_seen;
    b = {8'h00, 8'h00, 8'h00, 8'h00};
    r = {8'h5C, 8'h42, 8'h00};
    run_frame(b, r, 6, got);
    check("t1_miso1", {24'd0, got[1]}, 32'h00);
    check("t1_miso2", {24'd0, got[2]}, 32'h5C);
    check("t1_miso3", {24'd0, got[3]}, 32'h42);
    check("t1_strobes", strobe_seen - s0, 3);

    // osd frame
    s0 = strobe_seen;
    b = {8'h02, 8'h07, 8'hA5};
    r = {8'h11, 8'h22};
    run_frame(b, r, 6, got);
    check("t2_strobes", strobe_seen - s0, 2);
    check("t2_last_strobe", {28'd0, last_strobe}, 32'b0100);
    check("t2_last_dout", {24'd0, last_dout}, 32'hA5);
    check("t2_last_start", {31'd0, last_start}, 32'd0);

    // invalid target id
    s0 = strobe_seen;
    b = {8'h09, 8'h11, 8'h22, 8'h33};
    r = {};
    zero_watch = 1'b1;
    run_frame(b, r, 6, got);
    zero_watch = 1'b0;
    check("t3_strobes", strobe_seen - s0, 0);

    // CS raised mid command byte, then a clean hid frame
    s0 = strobe_seen;
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    xfer(8'h00, 8, 6, mb);
    xfer(8'hAB, 5, 6, mb);
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_partial_strobes", strobe_seen - s0, 0);
    b = {8'h01, 8'h3C};
    r = {8'h10};
    run_frame(b, r, 6, got);
    check("t4_last_strobe", {28'd0, last_strobe}, 32'b0010);
    check("t4_last_dout", {24'd0, last_dout}, 32'h3C);
    check("t4_last_start", {31'd0, last_start}, 32'd1);

    // reset mid-payload
    b = {8'h03, 8'h11, 8'h22};
    r = {8'h77, 8'h99};
    frame_setup(b, r, expm);
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) xfer(b[k], 8, 4, mb);
    xfer(8'h33, 3, 4, mb);
    repeat (4) @(negedge clk);
    check("t5_pre_dout", {24'd0, mcu_dout}, 32'h22);
    check("t5_pre_miso", {31'd0, spi_miso}, 32'd1);
    check("t5_pre_drain", exp_q.size(), 0);
    reset_n = 1'b0;
    #1;
    check("t5_rst_miso", {31'd0, spi_miso}, 32'd0);
    check("t5_rst_strobe", {28'd0, mcu_strobe}, 32'd0);
    check("t5_rst_start", {31'd0, mcu_start}, 32'd0);
    check("t5_rst_dout", {24'd0, mcu_dout}, 32'd0);
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    b = {8'h03, 8'h5A, 8'hC3};
    r = {8'h01, 8'h02};
    run_frame(b, r, 6, got);
    check("t5_after_miso1", {24'd0, got[1]}, 32'h99);
    check("t5_after_dout", {24'd0, last_dout}, 32'hC3);

    // random frames at exactly clk/8
    for (int f = 0; f < 256; f++) begin
      len = $urandom_range(2, 4);
      b = {};
      r = {};
      if ($urandom_range(0, 7) == 0) b.push_back(8'($urandom_range(4, 255)));
      else                           b.push_back(8'($urandom_range(0, 3)));
      for (int k = 1; k < len; k++) begin
        b.push_back(8'($urandom));
        r.push_back(8'($urandom));
      end
      run_frame(b, r, 4, got);
      reply_q = {};
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
